operand_fetch: RTL and testbench
================================

OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have inputs inValid (1), inOp (6), inRs1 (5), inRs2 (5), inRd (5), inImm (32): decoded instruction from decode stage.
REQ-004 SHALL have output inReady (1): instruction accepted on edge where inValid && inReady.
REQ-005 SHALL have outputs rAddrA (5), rAddrB (5) and inputs rDataA (32), rDataB (32): register-file read port, data registered one cycle after address sampled.
REQ-006 SHALL have inputs wbEn (1), wbAddr (5), wbData (32): snoop of the register-file write port, same cycle as register-file write.
REQ-007 SHALL have outputs outValid (1), outOp (6), outRd (5), outA (32), outB (32), outImm (32) and input outReady (1): operand bundle to execute; transfer on edge where outValid && outReady.

Function
REQ-008 SHALL implement FSM states IDLE, CAPTURE, OUT.
REQ-009 SHALL drive inReady = (state==IDLE) || (state==OUT && outReady), combinationally.
REQ-010 SHALL drive rAddrA/rAddrB = inRs1/inRs2 when inReady is 1, else the latched rs1/rs2.
REQ-011 On accept: latch op, rs1, rs2, rd, imm; go to CAPTURE.
REQ-012 IDLE with inValid=0 SHALL remain IDLE.
REQ-013 CAPTURE SHALL last exactly one cycle: on its closing edge load outA/outB from rDataA/rDataB (subject to bypass), load outOp/outRd/outImm, set outValid=1, go to OUT.
REQ-014 OUT with outReady=0 SHALL hold all out* stable except bypass updates (REQ-018).
REQ-015 OUT with outReady=1: inValid=1 -> accept, go to CAPTURE, outValid=0; inValid=0 -> go to IDLE, outValid=0.
REQ-016 Latency accept-edge to outValid=1 SHALL be 2 edges; sustained throughput one instruction per 2 cycles.
REQ-017 No special handling of register 0; address compares are full 5-bit equality.
REQ-018 Stall coherence: in OUT, wbEn=1 with wbAddr==rs1 (rs2) SHALL overwrite outA (outB) with wbData on that edge; both operands if both match.
REQ-019 Simultaneous outReady=1 and inValid=1 in OUT SHALL complete the transfer and the accept on the same edge with no bubble beyond CAPTURE.

Reset
REQ-020 rst_n=0 SHALL immediately force state IDLE, outValid=0, outOp/outRd=0, outA/outB/outImm=0, latched rs1/rs2/rd/op/imm=0, bypass registers cleared.
REQ-021 Reset asserted in CAPTURE or OUT SHALL discard the in-flight instruction; first accept possible on the first edge after release.

Configuration
REQ-022 Macro OPERAND_FETCH_BYPASS_EN SHALL compile in read-after-write bypass.
REQ-023 With macro: on accept edge, if wbEn && wbAddr==inRs1 (inRs2), SHALL record wbData as pending bypass for A (B), since register file returns pre-write value.
REQ-024 With macro: at CAPTURE closing edge, operand priority SHALL be current wbEn match > pending bypass > rDataA/B.
REQ-025 Without macro: outA/outB SHALL come from rDataA/rDataB only; REQ-018 still applies; no pending registers exist.

Verification
REQ-026 Reg 3=0x11, reg 4=0x22; accept rs1=3, rs2=4, outReady=1 -> outValid on 2nd edge, outA=0x11, outB=0x22, next state IDLE.
REQ-027 Accept rs1=5 same edge as wbEn, wbAddr=5, wbData=0xDEAD (old 0x0) -> with macro outA=0xDEAD; without macro outA=0x0.
REQ-028 In CAPTURE, wbEn, wbAddr=rs2=7, wbData=0xBEEF -> with macro outB=0xBEEF; without macro stale value.
REQ-029 Hold outReady=0 three cycles in OUT, write 0x1234 to rs1 -> outA becomes 0x1234, other outputs unchanged, inReady=0 throughout.
REQ-030 Back-to-back inValid=1, outReady=1 for four instructions -> outValid pulses every 2nd cycle, bundles in order, none lost.
REQ-031 Assert rst_n=0 mid-OUT with outValid=1 -> outValid=0 and out* zero immediately; inReady=1 after release.

Source files
------------

// File: rtl/operand_fetch.sv
// Operand fetch stage: latches a decoded instruction, reads the register
// file, and presents operands to execute. Optional macro OPERAND_FETCH_BYPASS_EN.
module operand_fetch (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inValid,
    input  logic [5:0]  inOp,
    input  logic [4:0]  inRs1,
    input  logic [4:0]  inRs2,
    input  logic [4:0]  inRd,
    input  logic [31:0] inImm,
    output logic        inReady,
    output logic [4:0]  rAddrA,
    output logic [4:0]  rAddrB,
    input  logic [31:0] rDataA,
    input  logic [31:0] rDataB,
    input  logic        wbEn,
    input  logic [4:0]  wbAddr,
    input  logic [31:0] wbData,
    output logic        outValid,
    output logic [5:0]  outOp,
    output logic [4:0]  outRd,
    output logic [31:0] outA,
    output logic [31:0] outB,
    output logic [31:0] outImm,
    input  logic        outReady
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        OUT     = 2'd2
    } state_e;

    state_e      state_q;
    state_e      state_d;

    logic [5:0]  op_q;
    logic [4:0]  rs1_q;
    logic [4:0]  rs2_q;
    logic [4:0]  rd_q;
    logic [31:0] imm_q;

    logic        outValid_q;
    logic [5:0]  outOp_q;
    logic [4:0]  outRd_q;
    logic [31:0] outA_q;
    logic [31:0] outB_q;
    logic [31:0] outImm_q;

    logic        accept;
    logic        wbHitA;
    logic        wbHitB;
    logic [31:0] opA_d;
    logic [31:0] opB_d;

    assign accept = inValid && inReady;
    assign wbHitA = wbEn && (wbAddr == rs1_q);
    assign wbHitB = wbEn && (wbAddr == rs2_q);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (inValid) begin
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                state_d = OUT;
            end
            OUT: begin
                if (outReady) begin
                    state_d = inValid ? CAPTURE : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Handshake and register-file address outputs
    always_comb begin
        inReady = (state_q == IDLE) ||
                  ((state_q == OUT) && outReady);
        rAddrA  = inReady ? inRs1 : rs1_q;
        rAddrB  = inReady ? inRs2 : rs2_q;
    end

    // Instruction fields captured on accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q  <= '0;
            rs1_q <= '0;
            rs2_q <= '0;
            rd_q  <= '0;
            imm_q <= '0;
        end else if (accept) begin
            op_q  <= inOp;
            rs1_q <= inRs1;
            rs2_q <= inRs2;
            rd_q  <= inRd;
            imm_q <= inImm;
        end
    end

`ifdef OPERAND_FETCH_BYPASS_EN
    logic        pendAVld_q;
    logic        pendBVld_q;
    logic [31:0] pendA_q;
    logic [31:0] pendB_q;

    // Writes landing on the accept edge are missed by the register file
    // read, so remember them for the capture edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pendAVld_q <= 1'b0;
            pendBVld_q <= 1'b0;
            pendA_q    <= '0;
            pendB_q    <= '0;
        end else if (accept) begin
            pendAVld_q <= wbEn && (wbAddr == inRs1);
            pendBVld_q <= wbEn && (wbAddr == inRs2);
            pendA_q    <= wbData;
            pendB_q    <= wbData;
        end
    end

    // Operand select: live write > pending write > register file
    always_comb begin
        opA_d = rDataA;
        opB_d = rDataB;
        if (wbHitA) begin
            opA_d = wbData;
        end else if (pendAVld_q) begin
            opA_d = pendA_q;
        end
        if (wbHitB) begin
            opB_d = wbData;
        end else if (pendBVld_q) begin
            opB_d = pendB_q;
        end
    end
`else
    // Operand select: register file data only
    always_comb begin
        opA_d = rDataA;
        opB_d = rDataB;
    end
`endif

    // Output bundle: load on capture, keep coherent with writes while held
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outValid_q <= 1'b0;
            outOp_q    <= '0;
            outRd_q    <= '0;
            outA_q     <= '0;
            outB_q     <= '0;
            outImm_q   <= '0;
        end else begin
            unique case (state_q)
                CAPTURE: begin
                    outValid_q <= 1'b1;
                    outOp_q    <= op_q;
                    outRd_q    <= rd_q;
                    outImm_q   <= imm_q;
                    outA_q     <= opA_d;
                    outB_q     <= opB_d;
                end
                OUT: begin
                    if (outReady) begin
                        outValid_q <= 1'b0;
                    end
                    if (wbHitA) begin
                        outA_q <= wbData;
                    end
                    if (wbHitB) begin
                        outB_q <= wbData;
                    end
                end
                default: begin
                    outValid_q <= outValid_q;
                end
            endcase
        end
    end

    assign outValid = outValid_q;
    assign outOp    = outOp_q;
    assign outRd    = outRd_q;
    assign outA     = outA_q;
    assign outB     = outB_q;
    assign outImm   = outImm_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Scoreboard bench for operand_fetch with a behavioural register file.
// Expectations follow OPERAND_FETCH_BYPASS_EN when it is defined.
module tb_operand_fetch;

`ifdef OPERAND_FETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct packed {
        logic [5:0]  op;
        logic [4:0]  rd;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
    } bundle_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        inValid;
    logic [5:0]  inOp;
    logic [4:0]  inRs1;
    logic [4:0]  inRs2;
    logic [4:0]  inRd;
    logic [31:0] inImm;
    logic        inReady;
    logic [4:0]  rAddrA;
    logic [4:0]  rAddrB;
    logic [31:0] rDataA;
    logic [31:0] rDataB;
    logic        wbEn;
    logic [4:0]  wbAddr;
    logic [31:0] wbData;
    logic        outValid;
    logic [5:0]  outOp;
    logic [4:0]  outRd;
    logic [31:0] outA;
    logic [31:0] outB;
    logic [31:0] outImm;
    logic        outReady;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    bundle_t sbq[$];
    int      pops[$];
    bundle_t exp_b;
    logic [31:0] regs [32] = '{default: 32'h0};

    always #5 clk = ~clk;

    operand_fetch dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .inValid  (inValid),
        .inOp     (inOp),
        .inRs1    (inRs1),
        .inRs2    (inRs2),
        .inRd     (inRd),
        .inImm    (inImm),
        .inReady  (inReady),
        .rAddrA   (rAddrA),
        .rAddrB   (rAddrB),
        .rDataA   (rDataA),
        .rDataB   (rDataB),
        .wbEn     (wbEn),
        .wbAddr   (wbAddr),
        .wbData   (wbData),
        .outValid (outValid),
        .outOp    (outOp),
        .outRd    (outRd),
        .outA     (outA),
        .outB     (outB),
        .outImm   (outImm),
        .outReady (outReady)
    );

    // Register file: registered read, read-before-write on the same edge
    always @(posedge clk) begin
        rDataA <= regs[rAddrA];
        rDataB <= regs[rAddrB];
        if (wbEn) regs[wbAddr] <= wbData;
        cyc <= cyc + 1;
    end

    // Output monitor: pop and compare on each transfer
    always @(negedge clk) begin
        if (rst_n === 1'b1 && outValid === 1'b1 && outReady === 1'b1) begin
            checks++;
            pops.push_back(cyc);
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_out op=%h rd=%h a=%h b=%h",
                         outOp, outRd, outA, outB);
            end else begin
                exp_b = sbq.pop_front();
                if ({outOp, outRd, outA, outB, outImm} !== exp_b) begin
                    errors++;
                    $display("FAIL bundle got op=%h rd=%h a=%h b=%h imm=%h want op=%h rd=%h a=%h b=%h imm=%h",
                             outOp, outRd, outA, outB, outImm,
                             exp_b.op, exp_b.rd, exp_b.a, exp_b.b, exp_b.imm);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rf_write(input logic [4:0] a, input logic [31:0] d);
        wbEn = 1'b1;
        wbAddr = a;
        wbData = d;
        tick();
        wbEn = 1'b0;
    endtask

    task automatic issue(input logic [5:0] op, input logic [4:0] s1,
                         input logic [4:0] s2, input logic [4:0] rd,
                         input logic [31:0] imm);
        inOp = op;
        inRs1 = s1;
        inRs2 = s2;
        inRd = rd;
        inImm = imm;
        inValid = 1'b1;
    endtask

    task automatic wait_drain(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (sbq.size() == 0) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        inValid = 0; inOp = 0; inRs1 = 0; inRs2 = 0; inRd = 0; inImm = 0;
        wbEn = 0; wbAddr = 0; wbData = 0; outReady = 0;
        #1 rst_n = 1'b0;
        #11;
        checks++;
        if (outValid !== 1'b0 || outA !== 32'h0 || outB !== 32'h0 ||
            outOp !== 6'h0 || outRd !== 5'h0 || outImm !== 32'h0) begin
            errors++;
            $display("FAIL reset_out valid=%b a=%h b=%h want all zero",
                     outValid, outA, outB);
        end
        checks++;
        if (inReady !== 1'b1) begin
            errors++;
            $display("FAIL reset_inready got %b want 1", inReady);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        bit ok;
        rf_write(5'd3, 32'h11);
        rf_write(5'd4, 32'h22);
        outReady = 1'b1;
        issue(6'h0A, 5'd3, 5'd4, 5'd9, 32'h100);
        #1;
        checks++;
        if (inReady !== 1'b1 || rAddrA !== 5'd3 || rAddrB !== 5'd4) begin
            errors++;
            $display("FAIL basic_idle rdy=%b ra=%0d rb=%0d want 1 3 4",
                     inReady, rAddrA, rAddrB);
        end
        sbq.push_back('{6'h0A, 5'd9, 32'h11, 32'h22, 32'h100});
        tick();
        inValid = 1'b0;
        inRs1 = 5'd0;
        #1;
        checks++;
        if (outValid !== 1'b0 || inReady !== 1'b0 || rAddrA !== 5'd3) begin
            errors++;
            $display("FAIL basic_capture v=%b rdy=%b ra=%0d want 0 0 3",
                     outValid, inReady, rAddrA);
        end
        tick();
        checks++;
        if (outValid !== 1'b1) begin
            errors++;
            $display("FAIL basic_latency outValid=%b want 1", outValid);
        end
        wait_drain(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL basic_drain pending=%0d want 0", sbq.size());
        end
        outReady = 1'b0;
        #1;
        checks++;
        if (inReady !== 1'b1 || outValid !== 1'b0) begin
            errors++;
            $display("FAIL basic_idle_after rdy=%b v=%b want 1 0",
                     inReady, outValid);
        end
    endtask

    task automatic test_bypass_accept();
        bit ok;
        outReady = 1'b1;
        issue(6'h11, 5'd5, 5'd6, 5'd1, 32'h0);
        wbEn = 1'b1;
        wbAddr = 5'd5;
        wbData = 32'hDEAD;
        sbq.push_back('{6'h11, 5'd1, BYP ? 32'hDEAD : regs[5],
                        regs[6], 32'h0});
        tick();
        inValid = 1'b0;
        wbEn = 1'b0;
        wait_drain(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL bypass_accept_drain pending=%0d want 0", sbq.size());
        end
    endtask

    task automatic test_bypass_capture();
        bit ok;
        rf_write(5'd7, 32'h77);
        outReady = 1'b1;
        issue(6'h12, 5'd1, 5'd7, 5'd2, 32'h7);
        sbq.push_back('{6'h12, 5'd2, regs[1],
                        BYP ? 32'hBEEF : 32'h77, 32'h7});
        tick();
        inValid = 1'b0;
        wbEn = 1'b1;
        wbAddr = 5'd7;
        wbData = 32'hBEEF;
        tick();
        wbEn = 1'b0;
        wait_drain(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL bypass_capture_drain pending=%0d want 0", sbq.size());
        end
    endtask

    task automatic test_stall();
        bit ok;
        rf_write(5'd10, 32'hA0);
        rf_write(5'd11, 32'hB0);
        outReady = 1'b0;
        issue(6'h03, 5'd10, 5'd11, 5'd4, 32'h55);
        tick();
        inValid = 1'b0;
        tick();
        checks++;
        if (outValid !== 1'b1 || outA !== 32'hA0 || inReady !== 1'b0) begin
            errors++;
            $display("FAIL stall_enter v=%b a=%h rdy=%b want 1 a0 0",
                     outValid, outA, inReady);
        end
        wbEn = 1'b1;
        wbAddr = 5'd10;
        wbData = 32'h1234;
        tick();
        wbEn = 1'b0;
        checks++;
        if (outA !== 32'h1234 || outB !== 32'hB0) begin
            errors++;
            $display("FAIL stall_bypass a=%h b=%h want 1234 b0", outA, outB);
        end
        checks++;
        if (outOp !== 6'h03 || outRd !== 5'd4 || outImm !== 32'h55 ||
            inReady !== 1'b0) begin
            errors++;
            $display("FAIL stall_hold op=%h rd=%h imm=%h rdy=%b want 03 4 55 0",
                     outOp, outRd, outImm, inReady);
        end
        tick();
        checks++;
        if (outA !== 32'h1234 || outValid !== 1'b1 || inReady !== 1'b0) begin
            errors++;
            $display("FAIL stall_third a=%h v=%b rdy=%b want 1234 1 0",
                     outA, outValid, inReady);
        end
        sbq.push_back('{6'h03, 5'd4, 32'h1234, 32'hB0, 32'h55});
        outReady = 1'b1;
        #1;
        checks++;
        if (inReady !== 1'b1) begin
            errors++;
            $display("FAIL stall_release rdy=%b want 1", inReady);
        end
        wait_drain(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL stall_drain pending=%0d want 0", sbq.size());
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        bit got;
        int acc[4];
        for (int i = 0; i < 8; i++) begin
            rf_write(5'(12 + i), 32'h1000 + 32'(i) * 32'h11);
        end
        outReady = 1'b1;
        pops.delete();
        for (int i = 0; i < 4; i++) begin
            issue(6'(i + 1), 5'(12 + 2 * i), 5'(13 + 2 * i),
                  5'(20 + i), 32'hC000 + 32'(i));
            sbq.push_back('{6'(i + 1), 5'(20 + i), regs[12 + 2 * i],
                            regs[13 + 2 * i], 32'hC000 + 32'(i)});
            got = 1'b0;
            for (int k = 0; k < 8; k++) begin
                #1;
                if (inReady === 1'b1) begin
                    acc[i] = cyc;
                    got = 1'b1;
                    tick();
                    break;
                end
                tick();
            end
            if (!got) begin
                checks++;
                errors++;
                $display("FAIL b2b_accept_timeout instr=%0d", i);
            end
        end
        inValid = 1'b0;
        wait_drain(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL b2b_drain pending=%0d want 0", sbq.size());
        end
        for (int i = 1; i < 4; i++) begin
            checks++;
            if (acc[i] - acc[i-1] != 2) begin
                errors++;
                $display("FAIL b2b_accept_gap i=%0d got %0d want 2",
                         i, acc[i] - acc[i-1]);
            end
        end
        checks++;
        if (pops.size() != 4) begin
            errors++;
            $display("FAIL b2b_pops got %0d want 4", pops.size());
        end else begin
            for (int i = 1; i < 4; i++) begin
                checks++;
                if (pops[i] - pops[i-1] != 2) begin
                    errors++;
                    $display("FAIL b2b_out_gap i=%0d got %0d want 2",
                             i, pops[i] - pops[i-1]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        rf_write(5'd2, 32'hCAFE);
        outReady = 1'b0;
        issue(6'h2A, 5'd2, 5'd2, 5'd7, 32'hFFFF);
        tick();
        inValid = 1'b0;
        tick();
        checks++;
        if (outValid !== 1'b1 || outA !== 32'hCAFE) begin
            errors++;
            $display("FAIL rstmid_pre v=%b a=%h want 1 cafe", outValid, outA);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (outValid !== 1'b0 || outA !== 32'h0 || outB !== 32'h0 ||
            outOp !== 6'h0 || outRd !== 5'h0 || outImm !== 32'h0) begin
            errors++;
            $display("FAIL rstmid_clear v=%b a=%h b=%h op=%h imm=%h want zero",
                     outValid, outA, outB, outOp, outImm);
        end
        checks++;
        if (inReady !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_ready got %b want 1", inReady);
        end
        #5;
        rst_n = 1'b1;
        outReady = 1'b1;
        issue(6'h01, 5'd3, 5'd4, 5'd5, 32'h6);
        sbq.push_back('{6'h01, 5'd5, regs[3], regs[4], 32'h6});
        #1;
        checks++;
        if (inReady !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_release_ready got %b want 1", inReady);
        end
        tick();
        inValid = 1'b0;
        checks++;
        if (outValid !== 1'b0 || inReady !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_first_accept v=%b rdy=%b want 0 0",
                     outValid, inReady);
        end
        wait_drain(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL rstmid_drain pending=%0d want 0", sbq.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bypass_accept();
        test_bypass_capture();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        tick();
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_left got %0d want 0", sbq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
